spi_slave_sync: RTL and testbench

System-clock-domain SPI slave. It is the parametrised successor of the SCLK-clocked SPI slave.
- SCLK, CS_n and MOSI are oversampled through synchronisers, with edge detection on i_CLK.
- Word width, SPI mode and bit order are set by parameters.
- TX uses a single-entry holding buffer with a valid/ready handshake. RX uses a one-cycle valid pulse.
- Adds continuous-burst support, an underrun flag and an abort flag.
- Sits between the SPI pins and the application logic. No logic is clocked by SCLK.

---
 rtl/spi_slave_sync.sv | 206 ++++++++++++++++++++
 tb/tb_spi_slave_sync.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_sync.sv
// SPI slave clocked entirely by i_CLK: SCLK, CS_n and MOSI are oversampled and edge-detected.
// Single-entry TX holding buffer (valid/ready), one-cycle RX valid pulse, burst, underrun and abort.
module spi_slave_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter int SPI_MODE    = 0,
  parameter bit MSB_FIRST   = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_n,
  input  logic                  i_SLAVE_TX_VALID,
  input  logic [DATA_WIDTH-1:0] i_SLAVE_TX_DATA,
  output logic                  o_SLAVE_TX_READY,
  output logic                  o_SLAVE_RX_VALID,
  output logic [DATA_WIDTH-1:0] o_SLAVE_RX_DATA,
  output logic                  o_SLAVE_TX_UNDERRUN,
  output logic                  o_SLAVE_ABORT,
  output logic                  o_SLAVE_BUSY,
  input  logic                  i_SLAVE_SPI_SCLK,
  input  logic                  i_SLAVE_SPI_CS_n,
  input  logic                  i_SLAVE_SPI_MOSI,
  output logic                  o_SLAVE_SPI_MISO,
  output logic                  o_SLAVE_SPI_MISO_OE
);

  localparam bit CPOL  = ((SPI_MODE / 2) % 2) == 1;
  localparam bit CPHA  = (SPI_MODE % 2) == 1;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] settle_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  // NOTE: synchroniser flops reset to the bus idle levels so that leaving reset never looks like an SPI edge.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      sclk_sync_q <= {SYNC_STAGES{CPOL}};
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      settle_q    <= '0;
      sclk_prev_q <= CPOL;
      cs_prev_q   <= 1'b1;
    end else begin
      // NOTE: every clocked assignment is non-blocking so all flops update from pre-edge values.
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_SLAVE_SPI_SCLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_SLAVE_SPI_CS_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_SLAVE_SPI_MOSI};
      settle_q    <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, mosi_s, settled;
  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise;

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign settled     = settle_q[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = ~cs_s & cs_prev_q;
  assign cs_rise     = cs_s & ~cs_prev_q;

  state_e                  state_q;
  logic                    armed_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic                    word_done_q;
  logic [DATA_WIDTH-1:0]   rx_shift_q;
  logic [DATA_WIDTH-1:0]   rx_data_q;
  logic                    rx_valid_q;
  logic [DATA_WIDTH-1:0]   tx_shift_q;
  logic [DATA_WIDTH-1:0]   hold_q;
  logic                    hold_full_q;
  logic                    underrun_q;
  logic                    urun_pend_q;
  logic                    abort_q;
  logic                    busy_q;

  logic                  tx_accept, entry, active_evt, burst_load, word_load;
  logic                  load_pt, load_empty, load_defer;
  logic [DATA_WIDTH-1:0] load_word, rx_shifted, tx_shifted;

  assign tx_accept  = i_SLAVE_TX_VALID & ~hold_full_q;
  assign entry      = (state_q == S_IDLE) & cs_fall & armed_q;
  assign active_evt = (state_q == S_ACTIVE) & ~cs_rise;
  assign burst_load = active_evt & shift_edge & word_done_q;
  assign word_load  = active_evt & shift_edge & (bit_cnt_q == '0);
  assign load_pt    = CPHA ? word_load : (entry | burst_load);
  assign load_word  = hold_full_q ? hold_q : (tx_accept ? i_SLAVE_TX_DATA : '0);
  assign load_empty = load_pt & ~hold_full_q & ~tx_accept;
  // A burst reload happens on the closing edge of every word, so its underrun only counts once the next word really starts.
  assign load_defer = load_empty & ~CPHA & burst_load;

  assign rx_shifted = MSB_FIRST ? {rx_shift_q[DATA_WIDTH-2:0], mosi_s}
                                : {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
  assign tx_shifted = MSB_FIRST ? {tx_shift_q[DATA_WIDTH-2:0], 1'b0}
                                : {1'b0, tx_shift_q[DATA_WIDTH-1:1]};

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q     <= S_IDLE;
      armed_q     <= 1'b0;
      bit_cnt_q   <= '0;
      word_done_q <= 1'b0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
      urun_pend_q <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
      underrun_q <= load_empty & ~load_defer;

      // A frame may only start after CS_n has genuinely been seen high since reset.
      if (settled && cs_s) armed_q <= 1'b1;

      if (load_pt && hold_full_q) begin
        hold_full_q <= 1'b0;
      end else if (tx_accept && !load_pt) begin
        hold_q      <= i_SLAVE_TX_DATA;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (entry) begin
            state_q     <= S_ACTIVE;
            busy_q      <= 1'b1;
            bit_cnt_q   <= '0;
            word_done_q <= 1'b0;
            urun_pend_q <= 1'b0;
            if (!CPHA) tx_shift_q <= load_word;
          end
        end
        S_ACTIVE: begin
          if (cs_rise) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            bit_cnt_q   <= '0;
            word_done_q <= 1'b0;
            urun_pend_q <= 1'b0;
            rx_shift_q  <= '0;
            if (bit_cnt_q != '0) begin
              abort_q    <= 1'b1;
              tx_shift_q <= '0;
            end
          end else begin
            if (sample_edge) begin
              rx_shift_q <= rx_shifted;
              if (urun_pend_q) begin
                underrun_q  <= 1'b1;
                urun_pend_q <= 1'b0;
              end
              if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_q   <= '0;
                rx_valid_q  <= 1'b1;
                rx_data_q   <= rx_shifted;
                word_done_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              end
            end
            if (shift_edge) begin
              if (load_pt) begin
                tx_shift_q  <= load_word;
                word_done_q <= 1'b0;
                urun_pend_q <= load_defer;
              end else begin
                tx_shift_q <= tx_shifted;
              end
            end
          end
        end
      endcase
    end
  end

  assign o_SLAVE_TX_READY    = ~hold_full_q;
  assign o_SLAVE_RX_VALID    = rx_valid_q;
  assign o_SLAVE_RX_DATA     = rx_data_q;
  assign o_SLAVE_TX_UNDERRUN = underrun_q;
  assign o_SLAVE_ABORT       = abort_q;
  assign o_SLAVE_BUSY        = busy_q;
  assign o_SLAVE_SPI_MISO    = MSB_FIRST ? tx_shift_q[DATA_WIDTH-1] : tx_shift_q[0];
  assign o_SLAVE_SPI_MISO_OE = busy_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: four instances (modes 0..3) driven by a behavioural SPI master;
// each frame is an exchange of words checked against what the master sent and what the application queued.
module tb_spi_slave_sync;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          sclk     [4];
  logic          cs_n     [4];
  logic          mosi     [4];
  logic          tx_valid [4];
  logic [DW-1:0] tx_data  [4];
  logic          tx_ready [4];
  logic          rx_valid [4];
  logic [DW-1:0] rx_data  [4];
  logic          urun     [4];
  logic          abort_o  [4];
  logic          busy     [4];
  logic          miso     [4];
  logic          miso_oe  [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_sync #(
      .DATA_WIDTH (DW),
      .SPI_MODE   (g),
      .MSB_FIRST  (g != 0),
      .SYNC_STAGES(2)
    ) u_dut (
      .i_CLK              (clk),
      .i_RST_n            (rst_n),
      .i_SLAVE_TX_VALID   (tx_valid[g]),
      .i_SLAVE_TX_DATA    (tx_data[g]),
      .o_SLAVE_TX_READY   (tx_ready[g]),
      .o_SLAVE_RX_VALID   (rx_valid[g]),
      .o_SLAVE_RX_DATA    (rx_data[g]),
      .o_SLAVE_TX_UNDERRUN(urun[g]),
      .o_SLAVE_ABORT      (abort_o[g]),
      .o_SLAVE_BUSY       (busy[g]),
      .i_SLAVE_SPI_SCLK   (sclk[g]),
      .i_SLAVE_SPI_CS_n   (cs_n[g]),
      .i_SLAVE_SPI_MOSI   (mosi[g]),
      .o_SLAVE_SPI_MISO   (miso[g]),
      .o_SLAVE_SPI_MISO_OE(miso_oe[g])
    );
  end

  int tests = 0;
  int fails = 0;

  int            rx_cnt    [4];
  int            urun_cnt  [4];
  int            abort_cnt [4];
  logic [DW-1:0] rx_last   [4];
  logic [DW-1:0] rx_prev   [4];

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rx_valid[k] === 1'b1) begin
        rx_prev[k] = rx_last[k];
        rx_last[k] = rx_data[k];
        rx_cnt[k]++;
      end
      if (urun[k] === 1'b1) urun_cnt[k]++;
      if (abort_o[k] === 1'b1) abort_cnt[k]++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit mode_cpol(input int u);
    return ((u / 2) % 2) == 1;
  endfunction

  function automatic bit mode_cpha(input int u);
    return (u % 2) == 1;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int u, input logic [DW-1:0] d);
    bit done = 1'b0;
    tx_valid[u] = 1'b1;
    tx_data[u]  = d;
    for (int k = 0; k < 50 && !done; k++) begin
      if (tx_ready[u] === 1'b1) done = 1'b1;
      @(negedge clk);
    end
    tx_valid[u] = 1'b0;
    check("push_accept", {31'd0, done}, 32'd1);
  endtask

  task automatic cs_low(input int u);
    cs_n[u] = 1'b0;
    cycles(8);
  endtask

  task automatic cs_high(input int u);
    cycles(4);
    cs_n[u] = 1'b1;
    cycles(8);
  endtask

  // Behavioural master: SCLK half-period of 4 system clocks, bit order and phase from the instance's mode.
  task automatic spi_word(input int u, input logic [DW-1:0] w, input int nbits, output logic [DW-1:0] cap);
    bit cpol = mode_cpol(u);
    bit cpha = mode_cpha(u);
    bit msb  = (u != 0);
    cap = '0;
    for (int i = 0; i < nbits; i++) begin
      int b;
      b = msb ? (DW - 1 - i) : i;
      if (!cpha) begin
        mosi[u] = w[b];
        cycles(4);
        sclk[u] = ~cpol;
        cap[b]  = miso[u];
        cycles(4);
        sclk[u] = cpol;
      end else begin
        sclk[u] = ~cpol;
        mosi[u] = w[b];
        cycles(4);
        sclk[u] = cpol;
        cap[b]  = miso[u];
        cycles(4);
      end
    end
  endtask

  initial begin
    logic [DW-1:0] cap0, cap1, t, r0, r1;
    int rx_b, ur_b, ab_b, u;
    bit pre;

    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sclk[k] = mode_cpol(k); cs_n[k] = 1'b1; mosi[k] = 1'b0;
      tx_valid[k] = 1'b0; tx_data[k] = '0;
      rx_cnt[k] = 0; urun_cnt[k] = 0; abort_cnt[k] = 0; rx_last[k] = '0; rx_prev[k] = '0;
    end
    cycles(3);
    check("reset_flags_m0", {25'd0, tx_ready[0], rx_valid[0], urun[0], abort_o[0], busy[0], miso[0], miso_oe[0]},
          32'h40);
    check("reset_rxdata_m0", {24'd0, rx_data[0]}, 32'h0);
    check("reset_flags_m3", {25'd0, tx_ready[3], rx_valid[3], urun[3], abort_o[3], busy[3], miso[3], miso_oe[3]},
          32'h40);
    rst_n = 1'b1;
    cycles(6);

    // Mode 0, LSB first: preload 0xA5, master sends 0x3C.
    rx_b = rx_cnt[0]; ur_b = urun_cnt[0]; ab_b = abort_cnt[0];
    push(0, 8'hA5);
    check("ready_low_when_full", {31'd0, tx_ready[0]}, 32'd0);
    cs_low(0);
    check("busy_in_frame", {30'd0, busy[0], miso_oe[0]}, 32'h3);
    check("ready_after_load", {31'd0, tx_ready[0]}, 32'd1);
    spi_word(0, 8'h3C, 8, cap0);
    cs_high(0);
    check("m0_miso_word", {24'd0, cap0}, 32'hA5);
    check("m0_rx_data", {24'd0, rx_last[0]}, 32'h3C);
    check("m0_rx_pulses", rx_cnt[0] - rx_b, 1);
    check("m0_no_abort", abort_cnt[0] - ab_b, 0);
    check("m0_no_underrun", urun_cnt[0] - ur_b, 0);
    check("busy_after_frame", {31'd0, busy[0]}, 32'd0);

    // Modes 1..3, MSB first: TX 0x81, master sends 0x7E.
    for (int m = 1; m < 4; m++) begin
      rx_b = rx_cnt[m]; ur_b = urun_cnt[m];
      push(m, 8'h81);
      cs_low(m);
      spi_word(m, 8'h7E, 8, cap0);
      cs_high(m);
      check($sformatf("mode%0d_miso_word", m), {24'd0, cap0}, 32'h81);
      check($sformatf("mode%0d_rx_data", m), {24'd0, rx_last[m]}, 32'h7E);
      check($sformatf("mode%0d_rx_pulses", m), rx_cnt[m] - rx_b, 1);
      check($sformatf("mode%0d_no_underrun", m), urun_cnt[m] - ur_b, 0);
    end

    // Continuous burst in mode 0: 0x11 preloaded, 0x22 queued once the frame has started.
    r0 = DW'($urandom_range(0, 255)); r1 = DW'($urandom_range(0, 255));
    rx_b = rx_cnt[0]; ur_b = urun_cnt[0];
    push(0, 8'h11);
    cs_low(0);
    push(0, 8'h22);
    spi_word(0, r0, 8, cap0);
    spi_word(0, r1, 8, cap1);
    cs_high(0);
    check("burst_miso_w1", {24'd0, cap0}, 32'h11);
    check("burst_miso_w2", {24'd0, cap1}, 32'h22);
    check("burst_rx_pulses", rx_cnt[0] - rx_b, 2);
    check("burst_rx_w1", {24'd0, rx_prev[0]}, {24'd0, r0});
    check("burst_rx_w2", {24'd0, rx_last[0]}, {24'd0, r1});
    check("burst_no_underrun", urun_cnt[0] - ur_b, 0);

    // Empty holding buffer at CS_n fall.
    r0 = DW'($urandom_range(0, 255));
    rx_b = rx_cnt[0]; ur_b = urun_cnt[0];
    cs_low(0);
    check("underrun_at_start", urun_cnt[0] - ur_b, 1);
    spi_word(0, r0, 8, cap0);
    cs_high(0);
    check("underrun_miso_zero", {24'd0, cap0}, 32'h0);
    check("underrun_rx_data", {24'd0, rx_last[0]}, {24'd0, r0});
    check("underrun_single", urun_cnt[0] - ur_b, 1);

    // Abort after 5 bits, then a clean frame carrying 0x5A.
    rx_b = rx_cnt[0]; ab_b = abort_cnt[0];
    push(0, DW'($urandom_range(0, 255)));
    cs_low(0);
    spi_word(0, DW'($urandom_range(0, 255)), 5, cap0);
    cs_high(0);
    check("abort_pulse", abort_cnt[0] - ab_b, 1);
    check("abort_no_rx", rx_cnt[0] - rx_b, 0);
    t = DW'($urandom_range(0, 255));
    push(0, t);
    cs_low(0);
    spi_word(0, 8'h5A, 8, cap0);
    cs_high(0);
    check("post_abort_rx", {24'd0, rx_last[0]}, 32'h5A);
    check("post_abort_miso", {24'd0, cap0}, {24'd0, t});
    check("post_abort_no_abort", abort_cnt[0] - ab_b, 1);

    // Reset mid-word with CS_n held low: SCLK must be ignored until a fresh CS_n fall.
    push(0, 8'hF0);
    cs_low(0);
    spi_word(0, 8'hFF, 3, cap0);
    rst_n = 1'b0;
    #1;
    check("midrst_flags", {25'd0, tx_ready[0], rx_valid[0], urun[0], abort_o[0], busy[0], miso[0], miso_oe[0]},
          32'h40);
    check("midrst_rxdata", {24'd0, rx_data[0]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(4);
    rx_b = rx_cnt[0];
    spi_word(0, 8'hC3, 8, cap0);
    cycles(4);
    check("midrst_ignored_busy", {31'd0, busy[0]}, 32'd0);
    check("midrst_ignored_rx", rx_cnt[0] - rx_b, 0);
    cs_high(0);
    t = DW'($urandom_range(0, 255)); r0 = DW'($urandom_range(0, 255));
    push(0, t);
    cs_low(0);
    spi_word(0, r0, 8, cap0);
    cs_high(0);
    check("midrst_next_rx", {24'd0, rx_last[0]}, {24'd0, r0});
    check("midrst_next_miso", {24'd0, cap0}, {24'd0, t});

    // Randomised single-word exchanges across all modes.
    for (int it = 0; it < 10; it++) begin
      u   = int'($urandom_range(0, 3));
      pre = 1'($urandom_range(0, 1));
      t   = DW'($urandom);
      r0  = DW'($urandom);
      rx_b = rx_cnt[u]; ur_b = urun_cnt[u]; ab_b = abort_cnt[u];
      if (pre) push(u, t);
      cs_low(u);
      spi_word(u, r0, 8, cap0);
      cs_high(u);
      check($sformatf("rand%0d_u%0d_rx", it, u), {24'd0, rx_last[u]}, {24'd0, r0});
      check($sformatf("rand%0d_u%0d_miso", it, u), {24'd0, cap0}, pre ? {24'd0, t} : 32'h0);
      check($sformatf("rand%0d_u%0d_urun", it, u), urun_cnt[u] - ur_b, pre ? 0 : 1);
      check($sformatf("rand%0d_u%0d_cnts", it, u), {rx_cnt[u] - rx_b, abort_cnt[u] - ab_b}, {32'd1, 32'd0});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
